operand_frame_serializer: RTL and testbench

- Upstream stage of the stochastic adder. Accepts pairs of 9-bit bipolar probability operands over a valid/ready handshake.
- Drives them onto two serial lines (adder inputs ui_in[0], ui_in[1]) in exactly the framed, LSB-first, periodic format the adder's 9-bit serial capture expects.
- One-deep pending buffer decouples the host from the ~2^17-cycle frame period.

---
 rtl/operand_frame_serializer_pkg.sv | 36 +++
 rtl/operand_frame_serializer_frame_phase_counter.sv | 55 +++++
 rtl/operand_frame_serializer.sv | 120 ++++++++++++
 tb/tb_operand_frame_serializer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_frame_serializer_pkg.sv
// ============================================================================
// Module   : operand_frame_serializer_pkg
// Purpose  : Frame geometry shared by the operand serializer and the
//            stochastic adder's serial capture. Both ends of the link read
//            these constants, so a change here moves them together.
// Contents : FRAME_DATA_W, FRAME_LEAD, FRAME_SHIFT_LEN, FRAME_PERIOD,
//            FRAME_INIT, phase state codes, phase_width() helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_frame_serializer_pkg;

  // Payload bits per frame and dummy slots ahead of the payload.
  localparam int FRAME_DATA_W    = 9;
  localparam int FRAME_LEAD      = 1;
  // Shift phase: leading dummy + payload + one trailing dummy.
  localparam int FRAME_SHIFT_LEN = FRAME_LEAD + FRAME_DATA_W + 1;
  // Adder capture window: 11 enabled cycles + 131059 disabled cycles.
  localparam int FRAME_PERIOD    = 131070;

  // Bipolar zero: half of the 9-bit range.
  localparam logic [FRAME_DATA_W-1:0] FRAME_INIT = 9'd256;

  // Frame phase, derived from the phase counter.
  localparam logic [0:0] ST_SHIFT = 1'b0;
  localparam logic [0:0] ST_GAP   = 1'b1;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int phase_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_frame_serializer_frame_phase_counter.sv
// ============================================================================
// Module   : frame_phase_counter
// Purpose  : Free-running frame phase counter p in 0..PERIOD-1 and the
//            frame-level strobes derived from it.
// Ports    : clk, rst_n (async, active-high)
//            o_p           - current slot index
//            o_frame_start - high during slot 0
//            o_shifting    - high during the shift phase (p < SHIFT_LEN)
//            o_last        - high during the last slot (p == PERIOD-1)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_phase_counter
  import operand_frame_serializer_pkg::*;
#(
  parameter int PERIOD    = FRAME_PERIOD,
  parameter int SHIFT_LEN = FRAME_SHIFT_LEN,
  parameter int P_W       = phase_width(FRAME_PERIOD)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [P_W-1:0] o_p,
  output logic           o_frame_start,
  output logic           o_shifting,
  output logic           o_last
);

  localparam logic [P_W-1:0] C_LAST      = P_W'(PERIOD - 1);
  localparam logic [P_W-1:0] C_SHIFT_LEN = P_W'(SHIFT_LEN);

  logic [P_W-1:0] r_p;
  logic [0:0]     w_state;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_p <= '0;
    end else if (r_p == C_LAST) begin
      r_p <= '0;
    end else begin
      r_p <= r_p + 1'b1;
    end
  end

  // SHIFT covers slots 0..SHIFT_LEN-1, GAP the rest of the period.
  assign w_state       = (r_p < C_SHIFT_LEN) ? ST_SHIFT : ST_GAP;

  assign o_p           = r_p;
  assign o_frame_start = (r_p == '0);
  assign o_shifting    = (w_state == ST_SHIFT);
  assign o_last        = (r_p == C_LAST);

endmodule

`default_nettype wire

// File: rtl/operand_frame_serializer.sv
// ============================================================================
// Module   : operand_frame_serializer
// Purpose  : Accepts 9-bit operand pairs over valid/ready and replays the
//            active pair every frame as two framed, LSB-first serial streams
//            for the stochastic adder's serial capture.
// Ports    : clk, rst_n (async, active-high)
//            in_valid/in_ready/in_a/in_b - host operand handshake
//            ser_a, ser_b                - serial operand streams
//            frame_start                 - high during slot 0
//            load_pulse                  - high in slot 0 of a frame that
//                                          carries a newly loaded pair
//            shifting                    - high during the shift phase
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_frame_serializer
  import operand_frame_serializer_pkg::*;
#(
  parameter int                DATA_W    = FRAME_DATA_W,
  parameter int                LEAD      = FRAME_LEAD,
  parameter int                SHIFT_LEN = FRAME_SHIFT_LEN,
  parameter int                PERIOD    = FRAME_PERIOD,
  parameter logic [DATA_W-1:0] INIT_A    = FRAME_INIT,
  parameter logic [DATA_W-1:0] INIT_B    = FRAME_INIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              ser_a,
  output logic              ser_b,
  output logic              frame_start,
  output logic              load_pulse,
  output logic              shifting
);

  localparam int             P_W       = phase_width(PERIOD);
  localparam int             IDX_W     = phase_width(DATA_W);
  localparam logic [P_W-1:0] C_LEAD    = P_W'(LEAD);
  localparam logic [P_W-1:0] C_PAY_END = P_W'(LEAD + DATA_W);

  logic [P_W-1:0]    w_p;
  logic              w_last;
  logic              w_xfer;
  logic              w_accept;
  logic              w_in_payload;
  logic [IDX_W-1:0]  w_idx;

  logic [DATA_W-1:0] r_act_a;
  logic [DATA_W-1:0] r_act_b;
  logic [DATA_W-1:0] r_pend_a;
  logic [DATA_W-1:0] r_pend_b;
  logic              r_pend_v;
  logic              r_load;

  frame_phase_counter #(
    .PERIOD    (PERIOD),
    .SHIFT_LEN (SHIFT_LEN),
    .P_W       (P_W)
  ) u_phase (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_p           (w_p),
    .o_frame_start (frame_start),
    .o_shifting    (shifting),
    .o_last        (w_last)
  );

  // Pending moves to active only across the last-slot edge, so a frame in
  // flight is never torn. The slot freed by that move can be refilled on
  // the very same edge.
  assign w_xfer   = w_last & r_pend_v;
  assign in_ready = ~r_pend_v | w_xfer;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_act_a  <= INIT_A;
      r_act_b  <= INIT_B;
      r_pend_a <= '0;
      r_pend_b <= '0;
      r_pend_v <= 1'b0;
      r_load   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_a <= in_a;
        r_pend_b <= in_b;
      end

      if (w_accept) begin
        r_pend_v <= 1'b1;
      end else if (w_xfer) begin
        r_pend_v <= 1'b0;
      end

      // No pending pair at the boundary: the active pair is resent.
      if (w_xfer) begin
        r_act_a <= r_pend_a;
        r_act_b <= r_pend_b;
      end

      r_load <= w_xfer;
    end
  end

  // Slot p carries bit p-LEAD; the capture samples it on the edge ending
  // the slot, so bit 0 occupies slot LEAD.
  assign w_in_payload = (w_p >= C_LEAD) && (w_p < C_PAY_END);
  assign w_idx        = IDX_W'(w_p - C_LEAD);

  assign ser_a      = w_in_payload & r_act_a[w_idx];
  assign ser_b      = w_in_payload & r_act_b[w_idx];
  assign load_pulse = r_load;

endmodule

`default_nettype wire

// File: tb/tb_operand_frame_serializer.sv
`default_nettype none

module tb_operand_frame_serializer;

  localparam int PERIOD    = 20;
  localparam int DATA_W    = 9;
  localparam int LEAD      = 1;
  localparam int SHIFT_LEN = 11;
  localparam logic [8:0] INIT_A = 9'd256;
  localparam logic [8:0] INIT_B = 9'd256;

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:0] in_a = '0;
  logic [8:0] in_b = '0;
  logic       in_ready, ser_a, ser_b, frame_start, load_pulse, shifting;

  operand_frame_serializer #(
    .DATA_W    (DATA_W),
    .LEAD      (LEAD),
    .SHIFT_LEN (SHIFT_LEN),
    .PERIOD    (PERIOD),
    .INIT_A    (INIT_A),
    .INIT_B    (INIT_B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .ser_a       (ser_a),
    .ser_b       (ser_b),
    .frame_start (frame_start),
    .load_pulse  (load_pulse),
    .shifting    (shifting)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  pair_t sb_q[$];     // expected frame contents, oldest first
  pair_t offer_q[$];  // host offers not yet accepted

  // Reference model state, valid for the slot currently on the outputs.
  int    m_p;
  pair_t m_act;
  pair_t m_pend;
  bit    m_pend_v;
  bit    m_load;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p      = 0;
    m_act    = '{a: INIT_A, b: INIT_B};
    m_pend   = '{a: 9'd0, b: 9'd0};
    m_pend_v = 1'b0;
    m_load   = 1'b0;
    sb_q.delete();
    sb_q.push_back(m_act);
  endtask

  // One slot: check the handshake/strobes, drive the host side, then step
  // the model to the next slot.
  task automatic body();
    bit exp_ready, acc, xfer;
    exp_ready = !m_pend_v || (m_p == PERIOD - 1);
    check("in_ready",    in_ready,    exp_ready);
    check("frame_start", frame_start, m_p == 0);
    check("shifting",    shifting,    m_p < SHIFT_LEN);
    check("load_pulse",  load_pulse,  m_load);

    if (offer_q.size() > 0) begin
      in_valid = 1'b1;
      in_a     = offer_q[0].a;
      in_b     = offer_q[0].b;
    end else begin
      in_valid = 1'b0;
      in_a     = 9'($urandom);
      in_b     = 9'($urandom);
    end

    acc  = in_valid && exp_ready;
    xfer = (m_p == PERIOD - 1) && m_pend_v;
    if (xfer) m_act = m_pend;
    if (acc) begin
      m_pend   = offer_q.pop_front();
      m_pend_v = 1'b1;
    end else if (xfer) begin
      m_pend_v = 1'b0;
    end
    m_load = xfer;
    m_p    = (m_p + 1) % PERIOD;
    if (m_p == 0) sb_q.push_back(m_act);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      body();
    end
  endtask

  // Returns at a falling edge where the model sits at slot 'target', with
  // that slot's body not yet executed.
  task automatic wait_phase(input int target);
    bit found = 1'b0;
    for (int i = 0; i <= PERIOD; i++) begin
      @(negedge clk);
      if (m_p == target) begin
        found = 1'b1;
        break;
      end
      body();
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_phase: slot %0d not reached, model at %0d", target, m_p);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ser_a"},       ser_a,       1'b0);
    check({tag, "_ser_b"},       ser_b,       1'b0);
    check({tag, "_frame_start"}, frame_start, 1'b1);
    check({tag, "_shifting"},    shifting,    1'b1);
    check({tag, "_load_pulse"},  load_pulse,  1'b0);
    check({tag, "_in_ready"},    in_ready,    1'b1);
  endtask

  // Assert reset at the current falling edge, hold it, release on a later
  // falling edge and run slot 0 of the fresh frame.
  task automatic do_reset(input string tag);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    offer_q.delete();
    #1;
    check_reset_outputs(tag);
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs({tag, "_hold"});
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    body();
  endtask

  // Monitor: rebuilds each frame from the serial lines the way the adder's
  // capture does and compares against the scoreboard.
  initial begin : monitor
    int    slot;
    pair_t cap;
    pair_t exp_pair;
    slot = -1;
    cap  = '{a: 9'd0, b: 9'd0};
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        slot = -1;
        continue;
      end
      if (frame_start) begin
        if (slot != -1) check("frame_length", slot, PERIOD);
        slot = 0;
      end
      if (slot >= 0) begin
        if (slot >= LEAD && slot < LEAD + DATA_W) begin
          cap.a[slot - LEAD] = ser_a;
          cap.b[slot - LEAD] = ser_b;
        end else begin
          check("idle_slot_zero", {ser_a, ser_b}, 2'b00);
        end
        if (slot == SHIFT_LEN - 1) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: got a=%0h b=%0h, expected no frame", cap.a, cap.b);
          end else begin
            exp_pair = sb_q.pop_front();
            check("frame_a", cap.a, exp_pair.a);
            check("frame_b", cap.b, exp_pair.b);
          end
        end
        slot++;
        if (slot > PERIOD) begin
          check("frame_length", slot, PERIOD);
          slot = -1;
        end
      end
    end
  end

  initial begin : stimulus
    // Power-on reset, then two frames of INIT operands.
    @(negedge clk);
    do_reset("por");
    run(2 * PERIOD);

    // Single load during a frame.
    wait_phase(3);
    offer_q.push_back('{a: 9'h0A5, b: 9'h13C});
    body();
    run(2 * PERIOD);

    // Back-to-back offers: second stalls until the boundary transfer.
    wait_phase(2);
    offer_q.push_back('{a: 9'h155, b: 9'h0AA});
    offer_q.push_back('{a: 9'h0F0, b: 9'h10F});
    body();
    run(3 * PERIOD);

    // Idle: last pair repeats with no load pulse.
    run(3 * PERIOD);

    // Boundary operand values.
    offer_q.push_back('{a: 9'h000, b: 9'h1FF});
    offer_q.push_back('{a: 9'h1FF, b: 9'h100});
    offer_q.push_back('{a: 9'h100, b: 9'h000});
    run(4 * PERIOD);

    // Reset at slot 5 of a loaded frame with a pair pending.
    wait_phase(0);
    offer_q.push_back('{a: 9'h0C3, b: 9'h13A});
    body();
    run(PERIOD - 1);
    offer_q.push_back('{a: 9'h1E7, b: 9'h018});
    wait_phase(5);
    check("pre_reset_pending", m_pend_v, 1'b1);
    do_reset("mid");
    run(2 * PERIOD);

    // Randomised offers with random idle gaps.
    for (int i = 0; i < 30 * PERIOD; i++) begin
      @(negedge clk);
      if (offer_q.size() == 0 && $urandom_range(0, 7) == 0)
        offer_q.push_back('{a: 9'($urandom), b: 9'($urandom)});
      body();
    end

    // Let the current frame's payload reach the monitor, then drain.
    offer_q.delete();
    wait_phase(SHIFT_LEN + 1);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
